// File: rtl/vga_mode_ctrl.sv
// ---------------------------------------------------------------------------
// vga_mode_ctrl
//
// Sequences a display-mode change for a VGA pipeline:
//   1. accept a mode request while idle (one-cycle ack),
//   2. if video is running, let the current frame finish, then blank video,
//   3. strobe the resolution memory to load the new mode's timing set,
//   4. wait for the memory to signal the load (its valid bit toggles),
//   5. wait for the pixel-clock generator to lock,
//   6. restart the timing generator and re-enable video.
// After reset the controller runs the same load sequence for DEFAULT_MODE.
//
// Optional feature: define VGA_MODE_CTRL_LOCK_TIMEOUT_EN to bound the lock
// wait by LOCK_TIMEOUT cycles; on expiry err_o is set and the controller
// returns to idle with video left disabled. Without the macro the lock wait
// is unbounded, LOCK_TIMEOUT does not exist and err_o is tied low.
//
// Parameters
//   DEFAULT_MODE  resolution loaded after reset
//   LOCK_TIMEOUT  lock-wait bound in cycles (macro builds only)
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous active-high reset
//   mode_req_i    mode-change request, held by the requester until acked
//   mode_i        requested mode, valid with mode_req_i
//   mode_ack_o    one-cycle pulse: request accepted
//   busy_o        high whenever the controller is not idle
//   frame_end_i   one-cycle pulse on the last pixel of a frame
//   res_req_o     load strobe to the resolution memory
//   res_mode_o    mode index presented to the resolution memory
//   res_valid_i   resolution-memory valid, toggles once per load strobe
//   pll_lock_i    pixel-clock lock, already synchronised to clk_i
//   timing_en_o   enables the timing generator and video output
//   timing_rst_o  one-cycle restart pulse to the timing generator
//   cur_mode_o    mode currently displayed
//   err_o         sticky lock-timeout flag
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package vga_mode_pkg;
    typedef enum logic [2:0] {
        VGA_RES_640_480   = 3'd0,
        VGA_RES_800_600   = 3'd1,
        VGA_RES_1024_768  = 3'd2,
        VGA_RES_1280_720  = 3'd3,
        VGA_RES_1280_1024 = 3'd4,
        VGA_RES_1920_1080 = 3'd5
    } resolution_e;
endpackage

module vga_mode_ctrl
    import vga_mode_pkg::*;
#(
    parameter resolution_e DEFAULT_MODE = VGA_RES_800_600
`ifdef VGA_MODE_CTRL_LOCK_TIMEOUT_EN
    ,
    parameter int unsigned LOCK_TIMEOUT = 1024
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mode_req_i,
    input  resolution_e mode_i,
    output logic        mode_ack_o,
    output logic        busy_o,
    input  logic        frame_end_i,
    output logic        res_req_o,
    output resolution_e res_mode_o,
    input  logic        res_valid_i,
    input  logic        pll_lock_i,
    output logic        timing_en_o,
    output logic        timing_rst_o,
    output resolution_e cur_mode_o,
    output logic        err_o
);

    // Each state's actions take effect on the clock edge that leaves it, so
    // the cycle after reset (state LOAD) is the one that issues the boot load
    // and the reset cycle itself never strobes the memory.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_LOAD       = 3'd2,
        S_WAIT_VALID = 3'd3,
        S_WAIT_LOCK  = 3'd4,
        S_RESTART    = 3'd5
    } state_e;

    state_e      state_reg;
    logic        busy_reg;
    logic        ack_reg;
    logic        res_req_reg;
    logic        timing_en_reg;
    logic        timing_rst_reg;
    logic        exp_valid_reg;
    resolution_e pend_mode_reg;
    resolution_e cur_mode_reg;

`ifdef VGA_MODE_CTRL_LOCK_TIMEOUT_EN
    // Counter runs 0 .. LOCK_TIMEOUT-1; the edge at which it holds the
    // terminal value is the LOCK_TIMEOUT-th cycle spent without lock.
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    logic [CNT_W-1:0] lock_cnt_reg;
    logic             err_reg;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= S_LOAD;
            busy_reg       <= 1'b1;
            ack_reg        <= 1'b0;
            res_req_reg    <= 1'b0;
            timing_en_reg  <= 1'b0;
            timing_rst_reg <= 1'b0;
            exp_valid_reg  <= 1'b0;
            pend_mode_reg  <= DEFAULT_MODE;
            cur_mode_reg   <= DEFAULT_MODE;
`ifdef VGA_MODE_CTRL_LOCK_TIMEOUT_EN
            lock_cnt_reg   <= '0;
            err_reg        <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; a state raises them for one cycle.
            ack_reg        <= 1'b0;
            res_req_reg    <= 1'b0;
            timing_rst_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (mode_req_i) begin
                        ack_reg       <= 1'b1;
                        pend_mode_reg <= mode_i;
`ifdef VGA_MODE_CTRL_LOCK_TIMEOUT_EN
                        err_reg       <= 1'b0;
`endif
                        // Re-requesting the mode already on screen is only
                        // a no-op while video runs; with video stopped (e.g.
                        // after a lock timeout) it retries the load.
                        if (mode_i == cur_mode_reg && timing_en_reg) begin
                            state_reg <= S_IDLE;
                        end else if (timing_en_reg) begin
                            state_reg <= S_WAIT_FRAME;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_LOAD;
                            busy_reg  <= 1'b1;
                        end
                    end
                end

                S_WAIT_FRAME: begin
                    // Switch only at a frame boundary so the visible frame
                    // is never torn; video is blanked from here on.
                    if (frame_end_i) begin
                        timing_en_reg <= 1'b0;
                        state_reg     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    res_req_reg   <= 1'b1;
                    exp_valid_reg <= res_valid_i;
                    state_reg     <= S_WAIT_VALID;
                end

                S_WAIT_VALID: begin
                    // The memory acknowledges a load by toggling valid, so a
                    // change relative to the captured level marks completion.
                    if (res_valid_i != exp_valid_reg) begin
                        state_reg    <= S_WAIT_LOCK;
`ifdef VGA_MODE_CTRL_LOCK_TIMEOUT_EN
                        lock_cnt_reg <= '0;
`endif
                    end
                end

                S_WAIT_LOCK: begin
                    if (pll_lock_i) begin
                        state_reg <= S_RESTART;
                    end
`ifdef VGA_MODE_CTRL_LOCK_TIMEOUT_EN
                    else if (lock_cnt_reg == CNT_LAST) begin
                        // Give up: video stays off and the displayed mode is
                        // left as it was, so a later request can retry.
                        err_reg   <= 1'b1;
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + CNT_W'(1);
                    end
`endif
                end

                S_RESTART: begin
                    timing_rst_reg <= 1'b1;
                    timing_en_reg  <= 1'b1;
                    cur_mode_reg   <= pend_mode_reg;
                    state_reg      <= S_IDLE;
                    busy_reg       <= 1'b0;
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mode_ack_o   = ack_reg;
    assign busy_o       = busy_reg;
    assign res_req_o    = res_req_reg;
    // The pending mode register doubles as the memory index: it is stable
    // from acceptance until the next request, covering the load strobe.
    assign res_mode_o   = pend_mode_reg;
    assign timing_en_o  = timing_en_reg;
    assign timing_rst_o = timing_rst_reg;
    assign cur_mode_o   = cur_mode_reg;

`ifdef VGA_MODE_CTRL_LOCK_TIMEOUT_EN
    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

endmodule
